// File: rtl/sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sb_pkg
//  Description : Shared types and helpers for the in-order store buffer:
//                entry-state encoding, entry record and byte-lane select.
//  Revision    : 1.0 - initial release
// ============================================================================
package sb_pkg;

    // Default ROB tag width; entries hold tags zero-extended to c_TAG_W_MAX
    localparam int c_TAG_W_DEFAULT = 3;
    localparam int c_TAG_W_MAX     = 16;

    // Entry-state encoding
    localparam logic [1:0] c_FREE      = 2'd0;
    localparam logic [1:0] c_PENDING   = 2'd1;
    localparam logic [1:0] c_COMMITTED = 2'd2;

    typedef logic [c_TAG_W_MAX-1:0] sb_tag_t;

    // One buffered store
    typedef struct packed {
        logic [1:0]  state;
        logic [31:0] addr;
        logic [31:0] data;
        logic        is_byte;
        sb_tag_t     tag;
    } sb_entry_t;

    // Little-endian byte lane of a word, zero-extended
    function automatic logic [31:0] sb_byte_sel(input logic [31:0] word, input logic [1:0] off);
        return {24'd0, word[{off, 3'b000} +: 8]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module      : sb_fwd_match
//  Description : Per-entry store-to-load match. o_match flags an entry that
//                decides the lookup (hit or stall); a byte store to a
//                different byte of the same word does not decide it.
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_fwd_match
    import sb_pkg::*;
(
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic        i_byte,
    input  logic [31:0] i_ld_addr,
    input  logic        i_ld_byte,
    output logic        o_match,
    output logic        o_hit,
    output logic        o_stall,
    output logic [31:0] o_data
);

    logic w_word_eq;

    assign w_word_eq = (i_addr[31:2] == i_ld_addr[31:2]);

    // Classify this entry against the load: forward, stall or no decision
    always_comb begin
        o_match = 1'b0;
        o_hit   = 1'b0;
        o_stall = 1'b0;
        o_data  = '0;
        if (i_valid && w_word_eq) begin
            if (!i_byte) begin
                o_match = 1'b1;
                o_hit   = 1'b1;
                o_data  = i_ld_byte ? sb_byte_sel(i_data, i_ld_addr[1:0]) : i_data;
            end else if (!i_ld_byte) begin
                // Word load over a byte store cannot be assembled here
                o_match = 1'b1;
                o_stall = 1'b1;
            end else if (i_addr[1:0] == i_ld_addr[1:0]) begin
                o_match = 1'b1;
                o_hit   = 1'b1;
                o_data  = {24'd0, i_data[7:0]};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : In-order store buffer between TL and the dcache. Stores are
//                held PENDING until the ROB commits them, then drained to the
//                dcache from the head. Loads search it youngest-first.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = c_TAG_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enq_valid,
    input  logic [31:0]             enq_addr,
    input  logic [31:0]             enq_data,
    input  logic                    enq_byte,
    input  logic [TAG_W-1:0]        enq_tag,
    output logic                    full,
    input  logic                    commit_valid,
    input  logic [TAG_W-1:0]        commit_tag,
    input  logic                    flush,
    input  logic                    ld_valid,
    input  logic [31:0]             ld_addr,
    input  logic                    ld_byte,
    output logic                    ld_hit,
    output logic [31:0]             ld_data,
    output logic                    ld_stall,
    output logic                    dc_req,
    output logic [31:0]             dc_addr,
    output logic [31:0]             dc_data,
    output logic                    dc_byte,
    input  logic                    dc_ack,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    sb_entry_t          r_entries_q [DEPTH];
    sb_entry_t          w_entries_d [DEPTH];
    logic [PTR_W-1:0]   r_head_q, w_head_d;
    logic [PTR_W-1:0]   r_tail_q, w_tail_d;
    logic [CNT_W-1:0]   r_count_q, w_count_d;

    logic [CNT_W-1:0]   w_ncomm;
    logic [PTR_W-1:0]   w_cidx;
    logic               w_commit;
    logic               w_pop;
    logic               w_full;
    logic               w_dc_req;

    logic [DEPTH-1:0]   w_rel, w_hit, w_stall;
    logic [31:0]        w_fdata [DEPTH];
    logic [PTR_W-1:0]   w_idx;
    logic               w_sel_hit, w_sel_stall;
    logic [31:0]        w_sel_data;

    assign w_full   = (r_count_q == CNT_W'(DEPTH));
    assign w_dc_req = (r_entries_q[r_head_q].state == c_COMMITTED);

    // Committed entries form a prefix from head, so their number locates the oldest pending one
    always_comb begin
        w_ncomm = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_entries_q[i].state == c_COMMITTED) begin
                w_ncomm = w_ncomm + c_CNT_ONE;
            end
        end
    end

    // Next state: commit, then pop alongside flush; flush suppresses enqueue
    always_comb begin
        w_entries_d = r_entries_q;
        w_head_d    = r_head_q;
        w_tail_d    = r_tail_q;
        w_count_d   = r_count_q;
        w_cidx      = r_head_q + w_ncomm[PTR_W-1:0];
        w_commit    = commit_valid && (w_ncomm < r_count_q) &&
                      (r_entries_q[w_cidx].tag == sb_tag_t'(commit_tag));
        w_pop       = dc_ack && w_dc_req;

        if (w_commit) begin
            w_entries_d[w_cidx].state = c_COMMITTED;
        end
        if (w_pop) begin
            w_entries_d[r_head_q].state = c_FREE;
            w_head_d = r_head_q + c_PTR_ONE;
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_entries_d[i].state == c_PENDING) begin
                    w_entries_d[i].state = c_FREE;
                end
            end
            w_tail_d  = r_head_q + w_ncomm[PTR_W-1:0] + (w_commit ? c_PTR_ONE : '0);
            w_count_d = w_ncomm + (w_commit ? c_CNT_ONE : '0) - (w_pop ? c_CNT_ONE : '0);
        end else begin
            if (enq_valid && !w_full) begin
                w_entries_d[r_tail_q] = '{state:   c_PENDING,
                                          addr:    enq_addr,
                                          data:    enq_data,
                                          is_byte: enq_byte,
                                          tag:     sb_tag_t'(enq_tag)};
                w_tail_d = r_tail_q + c_PTR_ONE;
            end
            w_count_d = r_count_q + ((enq_valid && !w_full) ? c_CNT_ONE : '0)
                                  - (w_pop ? c_CNT_ONE : '0);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries_q[i] <= '0;
            end
            r_head_q  <= '0;
            r_tail_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_entries_q <= w_entries_d;
            r_head_q    <= w_head_d;
            r_tail_q    <= w_tail_d;
            r_count_q   <= w_count_d;
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_match
            sb_fwd_match u_match (
                .i_valid   (r_entries_q[g].state != c_FREE),
                .i_addr    (r_entries_q[g].addr),
                .i_data    (r_entries_q[g].data),
                .i_byte    (r_entries_q[g].is_byte),
                .i_ld_addr (ld_addr),
                .i_ld_byte (ld_byte),
                .o_match   (w_rel[g]),
                .o_hit     (w_hit[g]),
                .o_stall   (w_stall[g]),
                .o_data    (w_fdata[g])
            );
        end
    endgenerate

    // Walk oldest to youngest starting at tail so the youngest deciding entry wins
    always_comb begin
        w_sel_hit   = 1'b0;
        w_sel_stall = 1'b0;
        w_sel_data  = '0;
        w_idx       = r_tail_q;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_tail_q + PTR_W'(k);
            if (w_rel[w_idx]) begin
                w_sel_hit   = w_hit[w_idx];
                w_sel_stall = w_stall[w_idx];
                w_sel_data  = w_fdata[w_idx];
            end
        end
    end

    assign ld_hit   = ld_valid && w_sel_hit;
    assign ld_stall = ld_valid && w_sel_stall;
    assign ld_data  = ld_valid ? w_sel_data : '0;

    assign full     = w_full;
    assign count    = r_count_q;
    assign dc_req   = w_dc_req;
    assign dc_addr  = w_dc_req ? r_entries_q[r_head_q].addr : '0;
    assign dc_data  = w_dc_req ? r_entries_q[r_head_q].data : '0;
    assign dc_byte  = w_dc_req && r_entries_q[r_head_q].is_byte;

endmodule
`default_nettype wire
